// File: rtl/cartridge_mem_arbiter_pkg.sv
// Shared constants for the cartridge memory arbiter: unified address map bases,
// arbiter FSM encodings and the region selector used by the address fold.
package cartridge_mem_arbiter_pkg;

   localparam logic [19:0] PRG_ROM_BASE = 20'h00000;
   localparam logic [19:0] CHR_BASE     = 20'h80000;
   localparam logic [19:0] PRG_RAM_BASE = 20'hC0000;

   localparam logic [1:0] ARB_IDLE    = 2'd0;
   localparam logic [1:0] ARB_CPU_ACC = 2'd1;
   localparam logic [1:0] ARB_PPU_ACC = 2'd2;
   localparam logic [1:0] ARB_DROP    = 2'd3;

   typedef enum logic [1:0] {
      REG_PRG_ROM = 2'd0,
      REG_CHR     = 2'd1,
      REG_PRG_RAM = 2'd2
   } cart_region_e;

endpackage

// File: rtl/cartridge_mem_arbiter_addr_unifier.sv
// cart_addr_unifier: folds PRG ROM, CHR and PRG RAM addresses into the
// 20-bit unified cartridge map. Purely combinational.
module cart_addr_unifier
   import cartridge_mem_arbiter_pkg::*;
(
   input  logic        chr_sel_i,
   input  logic        ram_sel_i,
   input  logic [18:0] prg_rom_addr_i,
   input  logic [14:0] prg_ram_addr_i,
   input  logic [17:0] chr_addr_i,
   output logic [19:0] addr_o
);

   cart_region_e region;

   // CHR wins over the RAM select because the PPU grant overrides CPU inputs.
   always_comb begin
      if (chr_sel_i)      region = REG_CHR;
      else if (ram_sel_i) region = REG_PRG_RAM;
      else                region = REG_PRG_ROM;
   end

   always_comb begin
      case (region)
         REG_CHR:     addr_o = CHR_BASE     | {2'b00, chr_addr_i};
         REG_PRG_RAM: addr_o = PRG_RAM_BASE | {5'b00000, prg_ram_addr_i};
         default:     addr_o = PRG_ROM_BASE | {1'b0, prg_rom_addr_i};
      endcase
   end

endmodule

// File: rtl/cartridge_mem_arbiter.sv
// Arbitrates CPU (PRG) and PPU (CHR) ports onto one byte-wide cartridge memory
// with req/ack sequencing and a timeout guard. Macro CART_ARB_ROUND_ROBIN_EN selects round-robin ties.
module cartridge_mem_arbiter
   import cartridge_mem_arbiter_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        cpu_req_i,
   input  logic        cpu_sel_ram_i,
   input  logic        cpu_we_i,
   input  logic [18:0] cpu_prg_rom_addr_i,
   input  logic [14:0] cpu_prg_ram_addr_i,
   input  logic [7:0]  cpu_wdata_i,
   output logic [7:0]  cpu_rdata_o,
   output logic        cpu_ack_o,
   input  logic        ppu_req_i,
   input  logic        ppu_we_i,
   input  logic [17:0] ppu_chr_addr_i,
   input  logic [7:0]  ppu_wdata_i,
   output logic [7:0]  ppu_rdata_o,
   output logic        ppu_ack_o,
   output logic        mem_req_o,
   output logic        mem_we_o,
   output logic [19:0] mem_addr_o,
   output logic [7:0]  mem_wdata_o,
   input  logic [7:0]  mem_rdata_i,
   input  logic        mem_ack_i,
   output logic        timeout_o
);

   localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

   logic [1:0]       state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [19:0]      addr_q;
   logic             we_q;
   logic [7:0]       wdata_q;
   logic             cpu_elig, ppu_elig, grant_cpu, grant_ppu;
   logic             in_acc, abort;
   logic [19:0]      uni_addr;

   // A port whose ack is pulsing this cycle is still holding req; ignore it.
   assign cpu_elig = cpu_req_i & ~cpu_ack_o;
   assign ppu_elig = ppu_req_i & ~ppu_ack_o;

`ifdef CART_ARB_ROUND_ROBIN_EN
   logic last_ppu_q;
   assign grant_ppu = ppu_elig & (~cpu_elig | ~last_ppu_q);
`else
   assign grant_ppu = ppu_elig;
`endif
   assign grant_cpu = cpu_elig & ~grant_ppu;

   cart_addr_unifier u_unifier (
      .chr_sel_i      (grant_ppu),
      .ram_sel_i      (cpu_sel_ram_i),
      .prg_rom_addr_i (cpu_prg_rom_addr_i),
      .prg_ram_addr_i (cpu_prg_ram_addr_i),
      .chr_addr_i     (ppu_chr_addr_i),
      .addr_o         (uni_addr)
   );

   assign in_acc      = (state_q == ARB_CPU_ACC) || (state_q == ARB_PPU_ACC);
   assign abort       = ~mem_ack_i && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
   assign mem_req_o   = in_acc;
   assign mem_we_o    = in_acc & we_q;
   assign mem_addr_o  = addr_q;
   assign mem_wdata_o = wdata_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= ARB_IDLE;
         cnt_q       <= '0;
         addr_q      <= '0;
         we_q        <= 1'b0;
         wdata_q     <= '0;
         cpu_rdata_o <= '0;
         ppu_rdata_o <= '0;
         cpu_ack_o   <= 1'b0;
         ppu_ack_o   <= 1'b0;
         timeout_o   <= 1'b0;
`ifdef CART_ARB_ROUND_ROBIN_EN
         last_ppu_q  <= 1'b0;
`endif
      end else begin
         cpu_ack_o <= 1'b0;
         ppu_ack_o <= 1'b0;
         case (state_q)
            ARB_IDLE: begin
               if (grant_cpu || grant_ppu) begin
                  addr_q <= uni_addr;
                  cnt_q  <= '0;
`ifdef CART_ARB_ROUND_ROBIN_EN
                  last_ppu_q <= grant_ppu;
`endif
                  if (grant_ppu) begin
                     we_q    <= ppu_we_i;
                     wdata_q <= ppu_wdata_i;
                     state_q <= ARB_PPU_ACC;
                  end else begin
                     we_q    <= cpu_we_i;
                     wdata_q <= cpu_wdata_i;
                     state_q <= (cpu_we_i && !cpu_sel_ram_i) ? ARB_DROP : ARB_CPU_ACC;
                  end
               end
            end
            ARB_CPU_ACC, ARB_PPU_ACC: begin
               if (mem_ack_i || abort) begin
                  state_q <= ARB_IDLE;
                  if (!mem_ack_i) timeout_o <= 1'b1;
                  if (state_q == ARB_CPU_ACC) begin
                     cpu_ack_o <= 1'b1;
                     if (!we_q) cpu_rdata_o <= mem_ack_i ? mem_rdata_i : 8'hFF;
                  end else begin
                     ppu_ack_o <= 1'b1;
                     if (!we_q) ppu_rdata_o <= mem_ack_i ? mem_rdata_i : 8'hFF;
                  end
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            ARB_DROP: begin
               cpu_ack_o <= 1'b1;
               state_q   <= ARB_IDLE;
            end
            default: state_q <= ARB_IDLE;
         endcase
      end
   end

endmodule
